lmac_tx_axis_arbiter: RTL

//  Frame-level round-robin arbiter sharing the single LMAC TX AXI-Stream port (tx_axis_mac_*) between two host requesters.

---
 rtl/lmac_tx_axis_arbiter_pkg.sv | 18 +
 rtl/lmac_tx_axis_arbiter_if.sv | 26 ++
 rtl/lmac_tx_axis_arbiter_rr_pick.sv | 20 ++
 rtl/lmac_tx_axis_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/lmac_tx_axis_arbiter_pkg.sv
// Shared definitions for the LMAC TX AXI-Stream frame arbiter.
// Holds the FSM state encoding and the default bus/timeout parameters.
package lmac_tx_axis_arbiter_pkg;

    localparam int AXIS_DW           = 64;
    localparam int AXIS_SW           = AXIS_DW / 8;
    localparam int DEFAULT_CNT_WIDTH = 32;
    localparam int DEFAULT_TIMEOUT   = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT0 = 3'd1,
        ST_GRANT1 = 3'd2,
        ST_ABORT  = 3'd3,
        ST_DRAIN  = 3'd4
    } arbState_t;

endpackage

// File: rtl/lmac_tx_axis_arbiter_if.sv
// AXI-Stream bundle used for both host source ports and the LMAC TX port.
// master drives the payload, slave drives tready.
interface lmac_tx_axis_arbiter_if
    import lmac_tx_axis_arbiter_pkg::*;
#(
    parameter int DW = AXIS_DW
) ();

    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic            tvalid;
    logic            tlast;
    logic            tuser;
    logic            tready;

    modport master (
        output tdata, tstrb, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tvalid, tlast, tuser,
        output tready
    );

endinterface

// File: rtl/lmac_tx_axis_arbiter_rr_pick.sv
// Two-way round-robin selector: picks the only requester, or the one that
// was not granted last when both request.
module lmac_tx_axis_arbiter_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_lastGrant,
    output logic       o_grant,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
        o_grant = 1'b0;
        case (i_req)
            2'b10:   o_grant = 1'b1;
            2'b11:   o_grant = ~i_lastGrant;
            default: o_grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/lmac_tx_axis_arbiter.sv
// Frame-level round-robin arbiter sharing the LMAC TX AXIS port between two
// host sources; a source that stalls mid-frame gets its frame aborted (tuser=1).
module lmac_tx_axis_arbiter
    import lmac_tx_axis_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DW,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset_,
    lmac_tx_axis_arbiter_if.slave  s0,
    lmac_tx_axis_arbiter_if.slave  s1,
    lmac_tx_axis_arbiter_if.master m,
    output logic                   grant_id,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   frm_cnt0,
    output logic [CNT_WIDTH-1:0]   frm_cnt1,
    output logic [CNT_WIDTH-1:0]   abort_cnt0,
    output logic [CNT_WIDTH-1:0]   abort_cnt1
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

    arbState_t            r_state;
    logic                 r_lastGrant;
    logic                 r_grantId;
    logic [WDOG_W-1:0]    r_wdog;
    logic [CNT_WIDTH-1:0] r_frmCnt0;
    logic [CNT_WIDTH-1:0] r_frmCnt1;
    logic [CNT_WIDTH-1:0] r_abortCnt0;
    logic [CNT_WIDTH-1:0] r_abortCnt1;

    logic w_pick;
    logic w_pickValid;
    logic w_selValid;
    logic w_selLast;

    lmac_tx_axis_arbiter_rr_pick u_rrPick (
        .i_req       ({s1.tvalid, s0.tvalid}),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_pick),
        .o_valid     (w_pickValid)
    );

    // r_lastGrant doubles as the owner of the frame in GRANT/ABORT/DRAIN.
    assign w_selValid = r_lastGrant ? s1.tvalid : s0.tvalid;
    assign w_selLast  = r_lastGrant ? s1.tlast  : s0.tlast;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state     <= ST_IDLE;
            r_lastGrant <= 1'b1;
            r_grantId   <= 1'b0;
            r_wdog      <= '0;
            r_frmCnt0   <= '0;
            r_frmCnt1   <= '0;
            r_abortCnt0 <= '0;
            r_abortCnt1 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wdog <= '0;
                    if (w_pickValid) begin
                        r_state     <= w_pick ? ST_GRANT1 : ST_GRANT0;
                        r_lastGrant <= w_pick;
                        r_grantId   <= w_pick;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    // Only a silent source trips the watchdog; sink backpressure never does.
                    if (w_selValid) begin
                        r_wdog <= '0;
                        if (m.tready && w_selLast) begin
                            if (r_lastGrant) r_frmCnt1 <= r_frmCnt1 + CNT_WIDTH'(1);
                            else             r_frmCnt0 <= r_frmCnt0 + CNT_WIDTH'(1);
                            r_state <= ST_IDLE;
                        end
                    end else if (r_wdog == WDOG_LIMIT) begin
                        r_wdog  <= '0;
                        r_state <= ST_ABORT;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                ST_ABORT: begin
                    if (m.tready) begin
                        if (r_lastGrant) r_abortCnt1 <= r_abortCnt1 + CNT_WIDTH'(1);
                        else             r_abortCnt0 <= r_abortCnt0 + CNT_WIDTH'(1);
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_selValid && w_selLast) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Zero-latency pass-through while granted; synthetic error beat while aborting.
    always_comb begin
        m.tdata   = '0;
        m.tstrb   = '0;
        m.tvalid  = 1'b0;
        m.tlast   = 1'b0;
        m.tuser   = 1'b0;
        s0.tready = 1'b0;
        s1.tready = 1'b0;
        case (r_state)
            ST_GRANT0: begin
                m.tdata   = s0.tdata;
                m.tstrb   = s0.tstrb;
                m.tvalid  = s0.tvalid;
                m.tlast   = s0.tlast;
                m.tuser   = s0.tuser;
                s0.tready = m.tready;
            end
            ST_GRANT1: begin
                m.tdata   = s1.tdata;
                m.tstrb   = s1.tstrb;
                m.tvalid  = s1.tvalid;
                m.tlast   = s1.tlast;
                m.tuser   = s1.tuser;
                s1.tready = m.tready;
            end
            ST_ABORT: begin
                m.tvalid = 1'b1;
                m.tlast  = 1'b1;
                m.tuser  = 1'b1;
                m.tstrb  = STRB_W'(1);
            end
            ST_DRAIN: begin
                if (r_lastGrant) s1.tready = 1'b1;
                else             s0.tready = 1'b1;
            end
            default: begin
                m.tvalid = 1'b0;
            end
        endcase
    end

    assign grant_id   = r_grantId;
    assign busy       = (r_state != ST_IDLE);
    assign frm_cnt0   = r_frmCnt0;
    assign frm_cnt1   = r_frmCnt1;
    assign abort_cnt0 = r_abortCnt0;
    assign abort_cnt1 = r_abortCnt1;

endmodule
